// File: rtl/mux_4_1.sv
// mux_4_1: registered 4-to-1 word multiplexer with output enable.
// One of a0..a3 is chosen by sel, zeroed when enb = 0, and presented on y
// one clock later together with the sel value that produced it.
// Bit vectors are big-endian: bit 0 is the MSB.
// Optional build macro MUX_4_1_PARITY_EN adds the registered even-parity
// output y_par (XOR reduction of the next-state word).
module mux_4_1 #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:WIDTH-1] a0,
    input  logic [0:WIDTH-1] a1,
    input  logic [0:WIDTH-1] a2,
    input  logic [0:WIDTH-1] a3,
    input  logic [0:1]       sel,
    input  logic             enb,
`ifdef MUX_4_1_PARITY_EN
    output logic             y_par,
`endif
    output logic [0:WIDTH-1] y,
    output logic [0:1]       y_sel
);

    // Per-bit one-hot decode of sel; keeps the datapath a flat AND-OR tree.
    logic [0:3]       w_dec;
    logic [0:WIDTH-1] w_nxt;

    // Decode select into one-hot lanes, gated by the enable.
    always_comb begin
        w_dec = 4'b0000;
        case (sel)
            2'd0:    w_dec = {enb, 3'b000};
            2'd1:    w_dec = {1'b0, enb, 2'b00};
            2'd2:    w_dec = {2'b00, enb, 1'b0};
            2'd3:    w_dec = {3'b000, enb};
            default: w_dec = {4{1'bx}};
        endcase
    end

    // Bit i of the result comes only from bit i of the chosen input.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_nxt[gi] = (w_dec[0] & a0[gi]) |
                               (w_dec[1] & a1[gi]) |
                               (w_dec[2] & a2[gi]) |
                               (w_dec[3] & a3[gi]);
        end
    endgenerate

    logic [0:WIDTH-1] r_y;
    logic [0:1]       r_y_sel;

    // Output register: reset wins over enable and select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_y_sel <= '0;
        end else begin
            r_y     <= w_nxt;
            r_y_sel <= sel;
        end
    end

    assign y     = r_y;
    assign y_sel = r_y_sel;

`ifdef MUX_4_1_PARITY_EN
    logic r_y_par;

    // Parity is taken from the gated word, so it is 0 whenever enb = 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_par <= 1'b0;
        end else begin
            r_y_par <= ^w_nxt;
        end
    end

    assign y_par = r_y_par;
`endif

endmodule

// File: tb/tb_mux_4_1.sv
// tb_mux_4_1: directed scoreboard bench for mux_4_1 (WIDTH = 24).
module tb_mux_4_1;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [0:W-1]  a0, a1, a2, a3;
    logic [0:1]    sel;
    logic          enb;
    logic [0:W-1]  y;
    logic [0:1]    y_sel;
`ifdef MUX_4_1_PARITY_EN
    logic          y_par;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [0:W-1] y;
        logic [0:1]   s;
        logic         p;
    } exp_t;

    exp_t sb[$];
    exp_t prev;
    bit   have_prev = 1'b0;

    mux_4_1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a0    (a0),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .sel   (sel),
        .enb   (enb),
`ifdef MUX_4_1_PARITY_EN
        .y_par (y_par),
`endif
        .y     (y),
        .y_sel (y_sel)
    );

    always #5 clk = ~clk;

    // Reference: pick the word by index, zero when disabled.
    function automatic logic [0:W-1] model(input logic e, input logic [0:1] s,
                                           input logic [0:W-1] v0, input logic [0:W-1] v1,
                                           input logic [0:W-1] v2, input logic [0:W-1] v3);
        logic [0:W-1] arr [4];
        arr[0] = v0; arr[1] = v1; arr[2] = v2; arr[3] = v3;
        if (!e) return '0;
        return arr[s];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction: drive inputs, confirm y has not moved yet, then
    // compare the registered result one edge later against the scoreboard.
    task automatic step(input string tag, input logic r, input logic e, input logic [0:1] s,
                        input logic [0:W-1] v0, input logic [0:W-1] v1,
                        input logic [0:W-1] v2, input logic [0:W-1] v3);
        exp_t x;
        exp_t got;
        rst = r; enb = e; sel = s; a0 = v0; a1 = v1; a2 = v2; a3 = v3;
        if (r) begin
            x.y = '0; x.s = 2'd0; x.p = 1'b0;
        end else begin
            x.y = model(e, s, v0, v1, v2, v3);
            x.s = s;
            x.p = ^x.y;
        end
        sb.push_back(x);
        #1;
        if (have_prev) chk({tag, "_hold"}, 32'(y), 32'(prev.y));
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, "_y"}, 32'(y), 32'(got.y));
        chk({tag, "_ysel"}, 32'(y_sel), 32'(got.s));
`ifdef MUX_4_1_PARITY_EN
        chk({tag, "_par"}, 32'(y_par), 32'(got.p));
`endif
        $display("step %-10s rst=%b enb=%b sel=%0d y=%h y_sel=%0d", tag, r, e, s, y, y_sel);
        prev = got;
        have_prev = 1'b1;
    endtask

    localparam logic [0:W-1] A0 = 24'h010101;
    localparam logic [0:W-1] A1 = 24'h020202;
    localparam logic [0:W-1] A2 = 24'h030303;
    localparam logic [0:W-1] A3 = 24'h040404;

    initial begin
        // Reset held two cycles with enb = 1, sel = 2.
        step("rst0", 1'b1, 1'b1, 2'd2, A0, A1, A2, A3);
        step("rst1", 1'b1, 1'b1, 2'd2, A0, A1, A2, A3);
        // Select sweep.
        step("sel0", 1'b0, 1'b1, 2'd0, A0, A1, A2, A3);
        step("sel1", 1'b0, 1'b1, 2'd1, A0, A1, A2, A3);
        step("sel2", 1'b0, 1'b1, 2'd2, A0, A1, A2, A3);
        step("sel3", 1'b0, 1'b1, 2'd3, A0, A1, A2, A3);
        // Enable gating.
        step("en1", 1'b0, 1'b1, 2'd3, A0, A1, A2, A3);
        step("en0", 1'b0, 1'b0, 2'd3, A0, A1, A2, A3);
        step("en1b", 1'b0, 1'b1, 2'd3, A0, A1, A2, A3);
        step("en0s2", 1'b0, 1'b0, 2'd2, A0, A1, A2, A3);
        // Back-to-back data on a1.
        step("b2b0", 1'b0, 1'b1, 2'd1, A0, 24'h0A0B0C, A2, A3);
        step("b2b1", 1'b0, 1'b1, 2'd1, A0, 24'hFFFFFF, A2, A3);
        step("b2b2", 1'b0, 1'b1, 2'd1, A0, 24'h000001, A2, A3);
        // Bit-exact placement (asymmetric patterns catch any reversal).
        step("bits2", 1'b0, 1'b1, 2'd2, A0, A1, 24'h800003, A3);
        step("bits3", 1'b0, 1'b1, 2'd3, A0, A1, A2, 24'hC00001);
        // Reset priority mid-stream and release.
        step("rstpri", 1'b1, 1'b1, 2'd0, A0, A1, A2, A3);
        step("rel", 1'b0, 1'b1, 2'd0, A0, A1, A2, A3);
        // Parity patterns (parity compared only when the feature is built).
        step("par1", 1'b0, 1'b1, 2'd0, 24'h010101, A1, A2, A3);
        step("par0", 1'b0, 1'b1, 2'd0, 24'h030303, A1, A2, A3);
        step("paren0", 1'b0, 1'b0, 2'd0, 24'h010101, A1, A2, A3);
        step("par1b", 1'b0, 1'b1, 2'd0, 24'h010101, A1, A2, A3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
